// File: rtl/bus_slot_arbiter_if.sv
// Slot arbiter bus: phase enable and requests in, grant/ack/refresh and phase status out.
interface bus_slot_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PHASES  = 8
);
    logic                      clk_en;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic                      refresh;
    logic [$clog2(PHASES)-1:0] bus_phase;
    logic                      cycle_ready;
    logic                      refresh_late;

    modport master (
        output clk_en, req,
        input  grant, ack, refresh, bus_phase, cycle_ready, refresh_late
    );

    modport slave (
        input  clk_en, req,
        output grant, ack, refresh, bus_phase, cycle_ready, refresh_late
    );
endinterface

// File: rtl/bus_slot_arbiter.sv
// RAM slot arbiter: owns the bus phase counter, picks one owner per slot among fixed-priority,
// round-robin and refresh channels, and pulses a per-channel ack when the granted access completes.
module bus_slot_arbiter #(
    parameter int                 NUM_REQ          = 4,
    parameter int                 PHASES           = 8,
    parameter int                 GRANT_PHASE      = 2,
    parameter int                 DONE_PHASE       = 4,
    parameter logic [NUM_REQ-1:0] PRIO_MASK        = {{(NUM_REQ-1){1'b0}}, 1'b1},
    parameter int                 REFRESH_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              n_reset,
    bus_slot_arbiter_if.slave bus
);
    localparam int PW   = $clog2(PHASES);
    localparam int RW   = $clog2(NUM_REQ);
    localparam int LATE = 2 * REFRESH_INTERVAL;
    localparam int CW   = (LATE == 0) ? 1 : $clog2(LATE + 1);

    localparam logic [PW-1:0]      PH_GRANT = PW'(GRANT_PHASE);
    localparam logic [PW-1:0]      PH_DONE  = PW'(DONE_PHASE);
    localparam logic [PW-1:0]      PH_LAST  = PW'(PHASES - 1);
    localparam logic [RW-1:0]      RR_LAST  = RW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      CNT_DUE  = CW'(REFRESH_INTERVAL);
    localparam logic [CW-1:0]      CNT_LATE = CW'(LATE);
    localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [PW-1:0]      phase_q;
    logic [CW-1:0]      ref_cnt;
    logic [RW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               refresh_q;

    logic               prio_hit, rr_hit, take_rr;
    logic [RW-1:0]      prio_sel, rr_sel, rr_next;
    logic [NUM_REQ-1:0] dec_grant;
    logic               dec_refresh;
    logic               refresh_due, late;

    assign late        = (LATE != 0) && (ref_cnt == CNT_LATE);
    assign refresh_due = (LATE != 0) && (ref_cnt >= CNT_DUE);

    always_comb begin
        int idx;
        idx      = 0;
        prio_hit = 1'b0;
        prio_sel = '0;
        rr_hit   = 1'b0;
        rr_sel   = '0;
        // Descending scans so the last overwrite is the lowest index / smallest offset from rr_ptr.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i] && PRIO_MASK[i]) begin
                prio_hit = 1'b1;
                prio_sel = RW'(i);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req[idx] && !PRIO_MASK[idx]) begin
                rr_hit = 1'b1;
                rr_sel = RW'(idx);
            end
        end
        rr_next = (rr_sel == RR_LAST) ? '0 : rr_sel + RW'(1);

        dec_grant   = '0;
        dec_refresh = 1'b0;
        take_rr     = 1'b0;
        if (late) begin
            dec_refresh = 1'b1;
        end else if (prio_hit) begin
            dec_grant = ONE << prio_sel;
        end else if (refresh_due) begin
            dec_refresh = 1'b1;
        end else if (rr_hit) begin
            dec_grant = ONE << rr_sel;
            take_rr   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            phase_q   <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            refresh_q <= 1'b0;
            rr_ptr    <= '0;
            ref_cnt   <= '0;
        end else begin
            ack_q <= '0;
            if (bus.clk_en) begin
                phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
                if (phase_q == PH_GRANT) begin
                    grant_q   <= dec_grant;
                    refresh_q <= dec_refresh;
                    if (take_rr) rr_ptr <= rr_next;
                    if (dec_refresh) ref_cnt <= '0;
                end
                // A dropped request still holds its grant to slot end, but earns no ack.
                if (phase_q == PH_DONE) ack_q <= grant_q & bus.req;
                if (phase_q == PH_LAST) begin
                    grant_q   <= '0;
                    refresh_q <= 1'b0;
                    if (LATE != 0 && ref_cnt != CNT_LATE) ref_cnt <= ref_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.ack          = ack_q;
    assign bus.refresh      = refresh_q;
    assign bus.bus_phase    = phase_q;
    assign bus.cycle_ready  = (phase_q == PH_LAST);
    assign bus.refresh_late = late;
endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Scoreboard bench: dut A (no refresh) and dut B (refresh interval 4) share clock, clk_en and reset.
module tb_bus_slot_arbiter;
    typedef struct {
        logic [3:0] grant;
        logic       refresh;
        logic [3:0] ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       clk_en = 1'b0;
    logic [3:0] reqa = '0, reqb = '0;
    int         vectors = 0, miscompares = 0;
    exp_t       q0[$], q1[$];

    bus_slot_arbiter_if #(.NUM_REQ(4), .PHASES(8)) ifa ();
    bus_slot_arbiter_if #(.NUM_REQ(4), .PHASES(8)) ifb ();

    assign ifa.clk_en = clk_en;
    assign ifb.clk_en = clk_en;
    assign ifa.req    = reqa;
    assign ifb.req    = reqb;

    bus_slot_arbiter #(.NUM_REQ(4), .PHASES(8), .GRANT_PHASE(2), .DONE_PHASE(4),
                       .PRIO_MASK(4'b0001), .REFRESH_INTERVAL(0)) dut_a (
        .clk(clk), .n_reset(n_reset), .bus(ifa));

    bus_slot_arbiter #(.NUM_REQ(4), .PHASES(8), .GRANT_PHASE(2), .DONE_PHASE(4),
                       .PRIO_MASK(4'b0001), .REFRESH_INTERVAL(4)) dut_b (
        .clk(clk), .n_reset(n_reset), .bus(ifb));

    logic [3:0] m_grant[2], m_ack[2];
    logic [2:0] m_phase[2];
    logic       m_ref[2], m_ready[2], m_late[2];
    assign m_grant[0] = ifa.grant;        assign m_grant[1] = ifb.grant;
    assign m_ack[0]   = ifa.ack;          assign m_ack[1]   = ifb.ack;
    assign m_phase[0] = ifa.bus_phase;    assign m_phase[1] = ifb.bus_phase;
    assign m_ref[0]   = ifa.refresh;      assign m_ref[1]   = ifb.refresh;
    assign m_ready[0] = ifa.cycle_ready;  assign m_ready[1] = ifb.cycle_ready;
    assign m_late[0]  = ifa.refresh_late; assign m_late[1]  = ifb.refresh_late;

    always #5 clk = ~clk;

    // clk_en high on every second edge; updated just after the edge, sampled at edge+4.
    always @(posedge clk) begin
        #2;
        clk_en = ~clk_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: per slot, accumulates acks and compares against the scoreboard at slot end.
    logic [3:0] acc[2];
    int         ackn[2];
    always @(posedge clk) begin
        exp_t e;
        #4;
        for (int d = 0; d < 2; d++) begin
            if (!n_reset) begin
                acc[d]  = '0;
                ackn[d] = 0;
            end else begin
                if (!$onehot0(m_grant[d]) || (m_ref[d] && |m_grant[d]) || |(m_ack[d] & ~m_grant[d])) begin
                    miscompares++;
                    $display("FAIL invariant dut%0d: grant %b refresh %b ack %b", d, m_grant[d], m_ref[d], m_ack[d]);
                end
                if (d == 0 && (m_ref[0] || m_late[0])) begin
                    miscompares++;
                    $display("FAIL no_refresh dut0: refresh %b late %b expected 0", m_ref[0], m_late[0]);
                end
                if (m_ack[d] != '0) begin
                    acc[d] = acc[d] | m_ack[d];
                    ackn[d]++;
                    if (m_phase[d] != 3'd5) begin
                        miscompares++;
                        $display("FAIL ack_phase dut%0d: got phase %0d expected 5", d, m_phase[d]);
                    end
                end
                if (m_ready[d] && clk_en) begin
                    if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        vectors++;
                        if (m_grant[d] !== e.grant || m_ref[d] !== e.refresh || acc[d] !== e.ack ||
                            ackn[d] != ((e.ack != '0) ? 1 : 0)) begin
                            miscompares++;
                            $display("FAIL slot dut%0d: got grant %b refresh %b ack %b (%0d pulses) expected grant %b refresh %b ack %b",
                                     d, m_grant[d], m_ref[d], acc[d], ackn[d], e.grant, e.refresh, e.ack);
                        end
                    end
                    acc[d]  = '0;
                    ackn[d] = 0;
                end
            end
        end
    end

    task automatic set_req(input int d, input logic [3:0] v);
        if (d == 0) reqa = v;
        else reqb = v;
    endtask

    task automatic wait_until(input int d, input logic [2:0] ph, input bit need_en);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (m_phase[d] == ph && (!need_en || clk_en)) found = 1'b1;
            else tick();
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout dut%0d: phase %0d not reached", d, ph);
        end
    endtask

    // Moves to the first clock of the next slot (phase 0).
    task automatic align(input int d);
        wait_until(d, 3'd7, 1'b1);
        tick();
    endtask

    // One slot: r0 from phase 0, r3 from phase 3 onward; expectation goes on the scoreboard.
    task automatic slot(input int d, input logic [3:0] r0, input logic [3:0] r3,
                        input logic [3:0] eg, input logic er, input logic [3:0] ea);
        exp_t e;
        e.grant = eg; e.refresh = er; e.ack = ea;
        set_req(d, r0);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        wait_until(d, 3'd3, 1'b0);
        set_req(d, r3);
        wait_until(d, 3'd7, 1'b1);
        tick();
    endtask

    initial begin
        logic [2:0] exp_ph;
        repeat (3) tick();
        chk("rst_phase_a", ifa.bus_phase, 0);
        chk("rst_grant_a", ifa.grant, 0);
        chk("rst_ack_a", ifa.ack, 0);
        chk("rst_refresh_b", ifb.refresh, 0);
        chk("rst_late_b", ifb.refresh_late, 0);
        chk("rst_ready_a", ifa.cycle_ready, 0);
        n_reset = 1'b1;

        // Phase counter sweep with no requests.
        exp_ph = 3'd0;
        for (int i = 0; i < 32; i++) begin
            chk("phase_sweep", ifa.bus_phase, exp_ph);
            chk("cycle_ready", ifa.cycle_ready, exp_ph == 3'd7);
            chk("idle_grant", ifa.grant, 0);
            if (clk_en) exp_ph = exp_ph + 3'd1;
            tick();
        end

        align(0);
        repeat (2) slot(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        // Round robin between ch1 and ch2.
        slot(0, 4'b0110, 4'b0110, 4'b0010, 1'b0, 4'b0010);
        slot(0, 4'b0110, 4'b0110, 4'b0100, 1'b0, 4'b0100);
        slot(0, 4'b0110, 4'b0110, 4'b0010, 1'b0, 4'b0010);
        slot(0, 4'b0110, 4'b0110, 4'b0100, 1'b0, 4'b0100);
        // Fixed-priority ch0 starves ch2 until it drops.
        repeat (3) slot(0, 4'b0101, 4'b0101, 4'b0001, 1'b0, 4'b0001);
        slot(0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0100);
        slot(0, 4'b0110, 4'b0110, 4'b0010, 1'b0, 4'b0010);
        // Late request waits for the next slot.
        slot(0, 4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b0000);
        slot(0, 4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000);
        // Dropped request: grant held, no ack.
        slot(0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0000);

        // Reset mid-slot after grant, before completion.
        set_req(0, 4'b1000);
        wait_until(0, 3'd3, 1'b0);
        chk("mid_grant", ifa.grant, 4'b1000);
        wait_until(0, 3'd4, 1'b0);
        n_reset = 1'b0;
        tick();
        chk("abort_grant", ifa.grant, 0);
        chk("abort_ack", ifa.ack, 0);
        chk("abort_phase", ifa.bus_phase, 0);
        chk("abort_ready", ifa.cycle_ready, 0);
        chk("abort_refresh", ifa.refresh, 0);
        tick();
        chk("abort_ack2", ifa.ack, 0);
        set_req(0, 4'b0000);
        n_reset = 1'b1;

        // Dut B: slot 0 after reset is idle (cnt 0 -> 1 at its end).
        align(1);
        repeat (2) begin
            repeat (3) slot(1, 4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010);
            slot(1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000);
        end
        // Priority ch0 beats a due refresh until the counter saturates.
        repeat (6) slot(1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001);
        chk("late_before", ifb.refresh_late, 0);
        slot(1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001);
        chk("late_set", ifb.refresh_late, 1);
        slot(1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000);
        chk("late_cleared", ifb.refresh_late, 0);
        slot(1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001);
        set_req(1, 4'b0000);

        tick();
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
